instr_fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the opcode decoder/control unit. It holds the PC, requests instruction words from instruction memory, and presents each fetched word with its opcode field and PC+4 to decode. It honours decode back-pressure (stall) and branch redirects from the execute stage. A one-entry skid buffer ensures no fetched word is lost or duplicated.

---
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, requests words from instruction memory and hands each word
// with its opcode and PC+4 to decode. Decode back-pressure is absorbed by a
// one-entry skid buffer. A taken redirect flushes everything and refetches.
// Optional build macro: IFETCH_PERF_EN adds fetch_count / stall_count.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [0:0]  ST_FETCH   = 1'b0;
  localparam logic [0:0]  ST_BLOCKED = 1'b1;
  localparam logic [31:0] PC_MASK    = 32'hFFFF_FFFC;

  logic [0:0]  state_r, state_n;
  logic [31:0] pc_r, pc_n;
  logic        valid_r, valid_n;
  logic [31:0] instr_r, instr_n;
  logic [31:0] pc4_r, pc4_n;
  logic [31:0] skid_instr_r, skid_instr_n;
  logic [31:0] skid_pc4_r, skid_pc4_n;
  logic [31:0] pc_plus4_s;
  logic        load_s;

  assign pc_plus4_s = pc_r + 32'd4;

  // Request only while fetching; a reset cycle never issues a request.
  assign imem_req  = (state_r == ST_FETCH) && !rst;
  assign imem_addr = pc_r;

  assign if_valid  = valid_r;
  assign if_instr  = instr_r;
  assign if_pc4    = pc4_r;
  // Opcode field is taken straight from IF/ID so it adds no latency.
  assign if_opcode = instr_r[31:26];

  // Next-state decision: redirect first, then the FETCH/BLOCKED handshake.
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    valid_n      = valid_r;
    instr_n      = instr_r;
    pc4_n        = pc4_r;
    skid_instr_n = skid_instr_r;
    skid_pc4_n   = skid_pc4_r;
    load_s       = 1'b0;
    if (redirect) begin
      // Flush: any word returned this cycle and the skid entry are dropped.
      state_n      = ST_FETCH;
      pc_n         = redirect_pc & PC_MASK;
      valid_n      = 1'b0;
      instr_n      = 32'h0000_0000;
      skid_instr_n = 32'h0000_0000;
      skid_pc4_n   = 32'h0000_0000;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_ready && !stall) begin
            valid_n = 1'b1;
            instr_n = imem_rdata;
            pc4_n   = pc_plus4_s;
            pc_n    = pc_plus4_s;
            load_s  = 1'b1;
          end else if (imem_ready) begin
            // Decode is busy: park the word and stop requesting.
            skid_instr_n = imem_rdata;
            skid_pc4_n   = pc_plus4_s;
            state_n      = ST_BLOCKED;
          end else if (!stall) begin
            // Nothing arrived: present a NOP bubble.
            valid_n = 1'b0;
            instr_n = 32'h0000_0000;
          end else begin
            state_n = ST_FETCH;
          end
        end
        ST_BLOCKED: begin
          if (!stall) begin
            valid_n      = 1'b1;
            instr_n      = skid_instr_r;
            pc4_n        = skid_pc4_r;
            pc_n         = pc_plus4_s;
            skid_instr_n = 32'h0000_0000;
            skid_pc4_n   = 32'h0000_0000;
            state_n      = ST_FETCH;
            load_s       = 1'b1;
          end else begin
            state_n = ST_BLOCKED;
          end
        end
        default: begin
          state_n = ST_FETCH;
        end
      endcase
    end
  end

  // State, PC, IF/ID and skid registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC & PC_MASK;
      valid_r      <= 1'b0;
      instr_r      <= 32'h0000_0000;
      pc4_r        <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
      skid_pc4_r   <= 32'h0000_0000;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      valid_r      <= valid_n;
      instr_r      <= instr_n;
      pc4_r        <= pc4_n;
      skid_instr_r <= skid_instr_n;
      skid_pc4_r   <= skid_pc4_n;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Performance counters: valid IF/ID loads and stalled valid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (load_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if (stall && valid_r) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign fetch_count = fetch_cnt_r;
  assign stall_count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. A transaction-level model
// (queue of accepted-but-undelivered words) is checked every cycle, and
// hand-computed literals pin the key scenarios. A second instance with
// RESET_PC=FFFF_FFF8 covers the reset-address wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ready, stall, redirect;
  logic [31:0] redirect_pc, data_off;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4;
  logic [5:0]  if_opcode;

  // Instruction memory: word = address + data_off.
  assign imem_rdata = imem_addr + data_off;

  logic        rst_b;
  logic        imem_req_b;
  logic [31:0] imem_addr_b, imem_rdata_b;
  logic        if_valid_b;
  logic [31:0] if_instr_b, if_pc4_b;
  logic [5:0]  if_opcode_b;
  assign imem_rdata_b = imem_addr_b;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count, stall_count, fetch_count_b, stall_count_b;
`endif

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_instr(if_instr), .if_opcode(if_opcode), .if_pc4(if_pc4)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_ready(1'b1), .imem_rdata(imem_rdata_b), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0000_0000), .if_valid(if_valid_b),
    .if_instr(if_instr_b), .if_opcode(if_opcode_b), .if_pc4(if_pc4_b)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count_b), .stall_count(stall_count_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words accepted from memory wait in q until decode takes them.
  logic        m_live = 1'b0, n_live;
  logic [31:0] m_fa, n_fa;
  logic        m_valid, n_valid;
  logic [31:0] m_instr, n_instr, m_pc4, n_pc4, m_fc, n_fc, m_sc, n_sc;
  logic [63:0] q[$];
  logic [63:0] n_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [63:0] e;
    n_q = q; n_live = m_live; n_fa = m_fa; n_valid = m_valid;
    n_instr = m_instr; n_pc4 = m_pc4; n_fc = m_fc; n_sc = m_sc;
    if (rst) begin
      n_live = 1'b1; n_q.delete(); n_fa = 32'h0000_0000;
      n_valid = 1'b0; n_instr = 32'h0; n_pc4 = 32'h0; n_fc = 32'd0; n_sc = 32'd0;
    end else begin
      if (stall && m_valid) n_sc = m_sc + 32'd1;
      if (redirect) begin
        n_q.delete();
        n_fa = redirect_pc & 32'hFFFF_FFFC;
        n_valid = 1'b0; n_instr = 32'h0;
      end else begin
        if (q.size() == 0 && imem_ready) begin
          n_q.push_back({m_fa + data_off, m_fa + 32'd4});
          n_fa = m_fa + 32'd4;
        end
        if (!stall) begin
          if (n_q.size() > 0) begin
            e = n_q.pop_front();
            n_valid = 1'b1; n_instr = e[63:32]; n_pc4 = e[31:0];
            n_fc = m_fc + 32'd1;
          end else begin
            n_valid = 1'b0; n_instr = 32'h0;
          end
        end
      end
    end
  endtask

  task automatic commit();
    q = n_q; m_live = n_live; m_fa = n_fa; m_valid = n_valid;
    m_instr = n_instr; m_pc4 = n_pc4; m_fc = n_fc; m_sc = n_sc;
  endtask

  // One clock cycle with the given inputs; returns 2 time units after the edge.
  task automatic cyc(input logic r, input logic rdy, input logic st,
                     input logic rd, input logic [31:0] rpc);
    rst = r; imem_ready = rdy; stall = st; redirect = rd; redirect_pc = rpc;
    model_step();
    @(posedge clk);
    commit();
    #2;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic exp_req;
    forever begin
      @(negedge clk);
      if (m_live) begin
        exp_req = !rst && (q.size() == 0);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("if_instr", if_instr, m_instr);
        chk("if_opcode", {26'd0, if_opcode}, {26'd0, m_instr[31:26]});
        if (m_valid) chk("if_pc4", if_pc4, m_pc4);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_fa);
`ifdef IFETCH_PERF_EN
        chk("fetch_count", fetch_count, m_fc);
        chk("stall_count", stall_count, m_sc);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; data_off = 32'h0; rst_b = 1'b1;
    m_fa = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_fc = 32'd0; m_sc = 32'd0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // Back-to-back fetch, memory word = address
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("seq0_instr", if_instr, 32'h0);
    chk("seq0_valid", {31'd0, if_valid}, 32'd1);
    chk("seq0_pc4", if_pc4, 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("seq1_instr", if_instr, 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("seq2_instr", if_instr, 32'h8);
    chk("seq2_pc4", if_pc4, 32'hC);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("seq3_instr", if_instr, 32'hC);
    chk("seq3_addr", imem_addr, 32'h10);

    // Stall during fetch of 0x10
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_hold_instr", if_instr, 32'hC);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("release_instr", if_instr, 32'h10);
    chk("release_addr", imem_addr, 32'h14);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("release_next", if_instr, 32'h14);

    // Redirect while stalled with the skid full
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("skid_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h1003);
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_instr", if_instr, 32'h0);
    chk("redir_addr", imem_addr, 32'h1000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_w0", if_instr, 32'h1000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_w1", if_instr, 32'h1004);
    chk("redir_w1_pc4", if_pc4, 32'h1008);

    // imem_ready toggling 1,0,1,0
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("tog0_instr", if_instr, 32'h1008);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("tog1_valid", {31'd0, if_valid}, 32'd0);
    chk("tog1_opcode", {26'd0, if_opcode}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("tog2_instr", if_instr, 32'h100C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("tog3_valid", {31'd0, if_valid}, 32'd0);
    chk("tog3_addr", imem_addr, 32'h1010);

    // Non-zero opcode field
    data_off = 32'hFC00_0000;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("opc_instr", if_instr, 32'hFC00_1010);
    chk("opc_opcode", {26'd0, if_opcode}, 32'h3F);
    data_off = 32'h0;

    // Reset while BLOCKED drops the skid word
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rstblk_valid", {31'd0, if_valid}, 32'd0);
    chk("rstblk_instr", if_instr, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rstblk_first", if_instr, 32'h0);
    chk("rstblk_pc4", if_pc4, 32'h4);

    // Redirect alignment and PC wrap
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_instr", if_instr, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Mixed directed pattern, checked by the model every cycle
    for (int i = 0; i < 48; i++) begin
      cyc((i == 29), ((i % 3) != 1), ((i % 5) == 2) || ((i % 7) == 4),
          (i == 19) || (i == 37), 32'h2001 + i * 32'h100);
    end

`ifdef IFETCH_PERF_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("perf_fetch", fetch_count, 32'd10);
    chk("perf_stall", stall_count, 32'd4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("perf_fetch_rst", fetch_count, 32'd0);
    chk("perf_stall_rst", stall_count, 32'd0);
`endif

    // RESET_PC = FFFF_FFF8 instance
    chk("b_rst_req", {31'd0, imem_req_b}, 32'd0);
    rst_b = 1'b0;
    #1;
    chk("b_first_addr", imem_addr_b, 32'hFFFF_FFF8);
    chk("b_first_req", {31'd0, imem_req_b}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("b_addr1", imem_addr_b, 32'hFFFF_FFFC);
    chk("b_instr0", if_instr_b, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("b_addr2", imem_addr_b, 32'h0);
    chk("b_instr1", if_instr_b, 32'hFFFF_FFFC);
    chk("b_pc4_1", if_pc4_b, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("b_instr2", if_instr_b, 32'h0);
    chk("b_pc4_2", if_pc4_b, 32'h4);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
